// File: rtl/pic_cw_sequencer_if.sv
// Handshake and PIC bus bundle for pic_cw_sequencer.
// Byte-wide fields use ascending ranges: index n carries PIC data bit Dn.
interface pic_cw_sequencer_if;
    logic       start;
    logic       single_mode;
    logic       level_trigger;
    logic       icw4_needed;
    logic       aeoi;
    logic [0:4] vector_base;
    logic [0:7] cascade_byte;
    logic [0:7] init_imr;
    logic       ocw_req;
    logic [0:1] ocw_sel;
    logic [0:7] ocw_data;
    logic       ocw_ack;
    logic       ocw_err;
    logic       cs_neg;
    logic       wr_neg;
    logic       a0;
    logic [0:7] data_bus_buffer;
    logic       busy;
    logic       init_done;

    modport master (
        output start, single_mode, level_trigger, icw4_needed, aeoi, vector_base,
               cascade_byte, init_imr, ocw_req, ocw_sel, ocw_data,
        input  ocw_ack, ocw_err, cs_neg, wr_neg, a0, data_bus_buffer, busy, init_done
    );

    modport slave (
        input  start, single_mode, level_trigger, icw4_needed, aeoi, vector_base,
               cascade_byte, init_imr, ocw_req, ocw_sel, ocw_data,
        output ocw_ack, ocw_err, cs_neg, wr_neg, a0, data_bus_buffer, busy, init_done
    );
endinterface

// File: rtl/pic_cw_sequencer.sv
// 8259-style ICW/OCW write sequencer driving cs_neg/wr_neg/a0/data.
// Optional PIC_CW_AUTO_OCW1_EN appends an OCW1 (init_imr) write to the ICW sequence.
module pic_cw_sequencer #(
    parameter int unsigned WR_PULSE = 2
) (
    input  logic               clk,
    input  logic               rst,
    pic_cw_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned VEC_W  = 5;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} bus_state_t;
    typedef enum logic [2:0] {
        ICW1, ICW2, ICW3, ICW4,
`ifdef PIC_CW_AUTO_OCW1_EN
        AOCW1,
`endif
        OCW
    } word_t;

    bus_state_t         state_q;
    word_t              word_q;
    word_t              next_word_c;
    logic               last_word_c;
    logic [CNT_W-1:0]   pulse_cnt_q;
    logic               single_q, icw4_q, aeoi_q;
    logic [VEC_W-1:0]   vec_q;
    logic [BYTE_W-1:0]  casc_q;
    logic               cs_neg_q, wr_neg_q, a0_q, busy_q, init_done_q;
    logic               ocw_ack_q, ocw_err_q, ocw_req_q;
    logic [BYTE_W-1:0]  data_q;
    logic [VEC_W-1:0]   vec_in_c;
    logic [BYTE_W-1:0]  casc_in_c, ocw_data_in_c, icw1_data_c, ocw_byte_c, nxt_data_c;
    logic               ocw_a0_c, nxt_a0_c;
    logic               start_acc_c, ocw_sel_ok_c, ocw_acc_c, ocw_rise_c, ocw_rej_c;
`ifdef PIC_CW_AUTO_OCW1_EN
    logic [BYTE_W-1:0]  imr_q, imr_in_c;
`endif

    // Reorder ascending-range ports into Dn-indexed internal vectors
    always_comb begin
        vec_in_c      = '0;
        casc_in_c     = '0;
        ocw_data_in_c = '0;
`ifdef PIC_CW_AUTO_OCW1_EN
        imr_in_c      = '0;
`endif
        for (int i = 0; i < int'(VEC_W); i++) vec_in_c[i] = bus.vector_base[i];
        for (int i = 0; i < int'(BYTE_W); i++) begin
            casc_in_c[i]     = bus.cascade_byte[i];
            ocw_data_in_c[i] = bus.ocw_data[i];
`ifdef PIC_CW_AUTO_OCW1_EN
            imr_in_c[i]      = bus.init_imr[i];
`endif
        end
    end

    always_comb begin
        icw1_data_c = {3'b000, 1'b1, bus.level_trigger, 1'b0, bus.single_mode, bus.icw4_needed};
        ocw_a0_c    = 1'b0;
        ocw_byte_c  = ocw_data_in_c;
        case (bus.ocw_sel)
            2'd1:    ocw_a0_c   = 1'b1;
            2'd2:    ocw_byte_c = ocw_data_in_c & 8'hE7;
            2'd3:    ocw_byte_c = (ocw_data_in_c & 8'h6F) | 8'h08;
            default: ;
        endcase
    end

    // Word sequencing: optional ICW3/ICW4 skipped according to captured mode bits
    always_comb begin
        next_word_c = word_q;
        last_word_c = 1'b1;
        nxt_a0_c    = 1'b0;
        nxt_data_c  = '0;
        case (word_q)
            ICW1: begin next_word_c = ICW2; last_word_c = 1'b0; end
            ICW2: begin
                if (!single_q) begin
                    next_word_c = ICW3; last_word_c = 1'b0;
                end else if (icw4_q) begin
                    next_word_c = ICW4; last_word_c = 1'b0;
                end
`ifdef PIC_CW_AUTO_OCW1_EN
                else begin
                    next_word_c = AOCW1; last_word_c = 1'b0;
                end
`endif
            end
            ICW3: begin
                if (icw4_q) begin
                    next_word_c = ICW4; last_word_c = 1'b0;
                end
`ifdef PIC_CW_AUTO_OCW1_EN
                else begin
                    next_word_c = AOCW1; last_word_c = 1'b0;
                end
`endif
            end
            ICW4: begin
`ifdef PIC_CW_AUTO_OCW1_EN
                next_word_c = AOCW1; last_word_c = 1'b0;
`endif
            end
            default: ;
        endcase
        case (next_word_c)
            ICW2:    begin nxt_a0_c = 1'b1; nxt_data_c = {vec_q, 3'b000}; end
            ICW3:    begin nxt_a0_c = 1'b1; nxt_data_c = casc_q; end
            ICW4:    begin nxt_a0_c = 1'b1; nxt_data_c = {6'b000000, aeoi_q, 1'b1}; end
`ifdef PIC_CW_AUTO_OCW1_EN
            AOCW1:   begin nxt_a0_c = 1'b1; nxt_data_c = imr_q; end
`endif
            default: ;
        endcase
    end

    assign start_acc_c  = (state_q == IDLE) && bus.start;
    assign ocw_sel_ok_c = (bus.ocw_sel != 2'd0);
    assign ocw_acc_c    = (state_q == IDLE) && !bus.start && bus.ocw_req && init_done_q && ocw_sel_ok_c;
    assign ocw_rise_c   = bus.ocw_req && !ocw_req_q;
    // A new request that cannot be served (not initialised, bad select, or pre-empted by start)
    assign ocw_rej_c    = ocw_rise_c && !ocw_acc_c && (start_acc_c || !init_done_q || !ocw_sel_ok_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= ICW1;
            pulse_cnt_q <= '0;
            single_q    <= 1'b0;
            icw4_q      <= 1'b0;
            aeoi_q      <= 1'b0;
            vec_q       <= '0;
            casc_q      <= '0;
`ifdef PIC_CW_AUTO_OCW1_EN
            imr_q       <= '0;
`endif
            cs_neg_q    <= 1'b1;
            wr_neg_q    <= 1'b1;
            a0_q        <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            ocw_ack_q   <= 1'b0;
            ocw_err_q   <= 1'b0;
            ocw_req_q   <= 1'b0;
        end else begin
            ocw_ack_q <= 1'b0;
            ocw_err_q <= ocw_rej_c;
            ocw_req_q <= bus.ocw_req;
            case (state_q)
                IDLE: begin
                    if (start_acc_c) begin
                        single_q    <= bus.single_mode;
                        icw4_q      <= bus.icw4_needed;
                        aeoi_q      <= bus.aeoi;
                        vec_q       <= vec_in_c;
                        casc_q      <= casc_in_c;
`ifdef PIC_CW_AUTO_OCW1_EN
                        imr_q       <= imr_in_c;
`endif
                        word_q      <= ICW1;
                        a0_q        <= 1'b0;
                        data_q      <= icw1_data_c;
                        cs_neg_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        init_done_q <= 1'b0;
                        state_q     <= SETUP;
                    end else if (ocw_acc_c) begin
                        word_q   <= OCW;
                        a0_q     <= ocw_a0_c;
                        data_q   <= ocw_byte_c;
                        cs_neg_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    wr_neg_q    <= 1'b0;
                    pulse_cnt_q <= CNT_W'(WR_PULSE - 1);
                    state_q     <= STROBE;
                end
                STROBE: begin
                    if (pulse_cnt_q == '0) begin
                        wr_neg_q <= 1'b1;
                        state_q  <= HOLD;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    cs_neg_q <= 1'b1;
                    a0_q     <= 1'b0;
                    data_q   <= '0;
                    state_q  <= GAP;
                end
                GAP: begin
                    if (!last_word_c) begin
                        word_q   <= next_word_c;
                        a0_q     <= nxt_a0_c;
                        data_q   <= nxt_data_c;
                        cs_neg_q <= 1'b0;
                        state_q  <= SETUP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (word_q == OCW) ocw_ack_q   <= 1'b1;
                        else               init_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < int'(BYTE_W); i++) bus.data_bus_buffer[i] = data_q[i];
    end

    assign bus.cs_neg    = cs_neg_q;
    assign bus.wr_neg    = wr_neg_q;
    assign bus.a0        = a0_q;
    assign bus.busy      = busy_q;
    assign bus.init_done = init_done_q;
    assign bus.ocw_ack   = ocw_ack_q;
    assign bus.ocw_err   = ocw_err_q;
endmodule

// File: tb/tb_pic_cw_sequencer.sv
// Directed self-checking bench for pic_cw_sequencer (default or PIC_CW_AUTO_OCW1_EN build).
module tb_pic_cw_sequencer;
    localparam int unsigned WR_PULSE = 2;
`ifdef PIC_CW_AUTO_OCW1_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pic_cw_sequencer_if ifc ();
    pic_cw_sequencer #(.WR_PULSE(WR_PULSE)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    // Bus capture results
    logic       cap_a0 [8];
    logic [7:0] cap_d [8];
    int         cap_wr_low [8];
    int         cap_n, cap_done_t, cap_ack, cap_err, cap_tail_bus;
    bit         cap_unstable, cap_idle_bad, cap_busy_bad;
    logic       cap_busy_at_done;

    function automatic logic [0:7] to_bus(input logic [7:0] d);
        logic [0:7] r;
        for (int i = 0; i < 8; i++) r[i] = d[i];
        return r;
    endfunction

    function automatic logic [7:0] from_bus(input logic [0:7] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[i];
        return r;
    endfunction

    task automatic drive_idle();
        ifc.start = 1'b0; ifc.single_mode = 1'b0; ifc.level_trigger = 1'b0;
        ifc.icw4_needed = 1'b0; ifc.aeoi = 1'b0; ifc.vector_base = 5'b00000;
        ifc.cascade_byte = 8'h00; ifc.init_imr = 8'h00;
        ifc.ocw_req = 1'b0; ifc.ocw_sel = 2'd0; ifc.ocw_data = 8'h00;
    endtask

    // Records every cs_neg-low write; mode 0 ends on init_done, mode 1 on the acks_needed-th ocw_ack
    task automatic capture(input int max_t, input int mode, input int acks_needed, input int poke_t);
        logic prev_cs;
        bit   done_now;
        cap_n = 0; cap_done_t = -1; cap_ack = 0; cap_err = 0; cap_tail_bus = 0;
        cap_unstable = 0; cap_idle_bad = 0; cap_busy_bad = 0; cap_busy_at_done = 1'bx;
        prev_cs = 1'b1;
        for (int t = 0; t <= max_t; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            ifc.start = (t == poke_t);
            if (ifc.ocw_err === 1'b1) begin cap_err++; ifc.ocw_req = 1'b0; end
            if (ifc.ocw_ack === 1'b1) cap_ack++;
            if (ifc.cs_neg === 1'b0) begin
                if (prev_cs && cap_n < 8) begin
                    cap_a0[cap_n] = ifc.a0; cap_d[cap_n] = from_bus(ifc.data_bus_buffer);
                    cap_wr_low[cap_n] = 0; cap_n++;
                end else if (cap_n > 0 && (ifc.a0 !== cap_a0[cap_n-1] ||
                             from_bus(ifc.data_bus_buffer) !== cap_d[cap_n-1])) begin
                    cap_unstable = 1;
                end
                if (ifc.wr_neg === 1'b0 && cap_n > 0) cap_wr_low[cap_n-1]++;
            end else if (ifc.a0 !== 1'b0 || ifc.data_bus_buffer !== 8'h00 || ifc.wr_neg !== 1'b1) begin
                cap_idle_bad = 1;
            end
            prev_cs = ifc.cs_neg;
            done_now = (mode == 0) ? (ifc.init_done === 1'b1) : (cap_ack == acks_needed);
            if (done_now) begin
                cap_done_t = t; cap_busy_at_done = ifc.busy;
                if (mode == 1) ifc.ocw_req = 1'b0;
                break;
            end else if (mode == 0 && ifc.busy !== 1'b1) begin
                cap_busy_bad = 1;
            end
        end
        ifc.start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            if (ifc.ocw_ack === 1'b1) cap_ack++;
            if (ifc.ocw_err === 1'b1) begin cap_err++; ifc.ocw_req = 1'b0; end
            if (ifc.cs_neg !== 1'b1) cap_tail_bus++;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst = 1'b1;
        #1;
        checks++; if (ifc.cs_neg !== 1'b1) begin errors++; $display("FAIL reset_cs_neg: got %b want 1", ifc.cs_neg); end
        checks++; if (ifc.wr_neg !== 1'b1) begin errors++; $display("FAIL reset_wr_neg: got %b want 1", ifc.wr_neg); end
        checks++; if (ifc.a0 !== 1'b0) begin errors++; $display("FAIL reset_a0: got %b want 0", ifc.a0); end
        checks++; if (ifc.data_bus_buffer !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", ifc.data_bus_buffer); end
        checks++; if (ifc.busy !== 1'b0 || ifc.init_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", ifc.busy, ifc.init_done); end
        checks++; if (ifc.ocw_ack !== 1'b0 || ifc.ocw_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b%b want 00", ifc.ocw_ack, ifc.ocw_err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        begin
            int cs_low = 0;
            repeat (5) begin @(posedge clk); #1; if (ifc.cs_neg !== 1'b1 || ifc.wr_neg !== 1'b1) cs_low++; end
            checks++; if (cs_low != 0) begin errors++; $display("FAIL post_reset_quiet: bus active %0d cycles want 0", cs_low); end
        end
    endtask

    task automatic test_ocw_before_init();
        int n_err = 0, cs_low = 0;
        ifc.ocw_sel = 2'd2; ifc.ocw_data = to_bus(8'h55); ifc.ocw_req = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (ifc.ocw_err === 1'b1) n_err++;
            if (ifc.cs_neg !== 1'b1 || ifc.busy !== 1'b0) cs_low++;
        end
        ifc.ocw_req = 1'b0;
        checks++; if (n_err != 1) begin errors++; $display("FAIL early_ocw_err_pulses: got %0d want 1", n_err); end
        checks++; if (cs_low != 0) begin errors++; $display("FAIL early_ocw_bus: active %0d cycles want 0", cs_low); end
        @(posedge clk); #1;
    endtask

    task automatic test_icw_single();
        logic [7:0] ed [5];
        logic       ea [5];
        int         en;
        ed = '{8'h12, 8'h88, 8'hA5, 8'h00, 8'h00};
        ea = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        en = 2 + EXTRA;
        ifc.single_mode = 1'b1; ifc.icw4_needed = 1'b0; ifc.level_trigger = 1'b0; ifc.aeoi = 1'b0;
        ifc.vector_base = 5'b10001; ifc.cascade_byte = to_bus(8'hFF); ifc.init_imr = to_bus(8'hA5);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        capture(60, 0, 0, 3);
        checks++; if (cap_n != en) begin errors++; $display("FAIL single_count: got %0d want %0d", cap_n, en); end
        for (int i = 0; i < en && i < cap_n; i++) begin
            checks++; if (cap_a0[i] !== ea[i] || cap_d[i] !== ed[i]) begin errors++; $display("FAIL single_word%0d: got a0=%b d=%h want a0=%b d=%h", i, cap_a0[i], cap_d[i], ea[i], ed[i]); end
            checks++; if (cap_wr_low[i] != int'(WR_PULSE)) begin errors++; $display("FAIL single_strobe%0d: got %0d want %0d", i, cap_wr_low[i], WR_PULSE); end
        end
        checks++; if (cap_done_t != 5 * en) begin errors++; $display("FAIL single_done_latency: got %0d want %0d", cap_done_t, 5 * en); end
        checks++; if ({cap_unstable, cap_idle_bad, cap_busy_bad} !== 3'b000) begin errors++; $display("FAIL single_protocol: got %b want 000", {cap_unstable, cap_idle_bad, cap_busy_bad}); end
        checks++; if (cap_busy_at_done !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", cap_busy_at_done); end
        checks++; if (cap_tail_bus != 0 || cap_err != 0) begin errors++; $display("FAIL single_tail: got bus=%0d err=%0d want 0 0", cap_tail_bus, cap_err); end
    endtask

    task automatic test_icw_full();
        logic [7:0] ed [5];
        logic       ea [5];
        int         en;
        ed = '{8'h11, 8'h18, 8'h04, 8'h03, 8'h3C};
        ea = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        en = 4 + EXTRA;
        ifc.single_mode = 1'b0; ifc.icw4_needed = 1'b1; ifc.level_trigger = 1'b0; ifc.aeoi = 1'b1;
        ifc.vector_base = 5'b11000; ifc.cascade_byte = to_bus(8'h04); ifc.init_imr = to_bus(8'h3C);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        checks++; if (ifc.init_done !== 1'b0) begin errors++; $display("FAIL full_reinit_clear: got %b want 0", ifc.init_done); end
        capture(60, 0, 0, -1);
        checks++; if (cap_n != en) begin errors++; $display("FAIL full_count: got %0d want %0d", cap_n, en); end
        for (int i = 0; i < en && i < cap_n; i++) begin
            checks++; if (cap_a0[i] !== ea[i] || cap_d[i] !== ed[i]) begin errors++; $display("FAIL full_word%0d: got a0=%b d=%h want a0=%b d=%h", i, cap_a0[i], cap_d[i], ea[i], ed[i]); end
        end
        checks++; if (cap_done_t != 5 * en) begin errors++; $display("FAIL full_done_latency: got %0d want %0d", cap_done_t, 5 * en); end
        checks++; if ({cap_unstable, cap_idle_bad, cap_busy_bad} !== 3'b000) begin errors++; $display("FAIL full_protocol: got %b want 000", {cap_unstable, cap_idle_bad, cap_busy_bad}); end
    endtask

    task automatic test_ocw();
        logic [1:0] sel [3];
        logic [7:0] din [3];
        logic [7:0] dexp [3];
        logic       aexp [3];
        sel  = '{2'd3, 2'd2, 2'd1};
        din  = '{8'hFF, 8'hFF, 8'h5A};
        dexp = '{8'h6F, 8'hE7, 8'h5A};
        aexp = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            ifc.ocw_sel = sel[k]; ifc.ocw_data = to_bus(din[k]); ifc.ocw_req = 1'b1;
            @(posedge clk); #1;
            capture(30, 1, 1, -1);
            checks++; if (cap_n != 1) begin errors++; $display("FAIL ocw%0d_count: got %0d want 1", sel[k], cap_n); end
            checks++; if (cap_n > 0 && (cap_a0[0] !== aexp[k] || cap_d[0] !== dexp[k])) begin errors++; $display("FAIL ocw%0d_word: got a0=%b d=%h want a0=%b d=%h", sel[k], cap_a0[0], cap_d[0], aexp[k], dexp[k]); end
            checks++; if (cap_done_t != 5 || cap_ack != 1) begin errors++; $display("FAIL ocw%0d_ack: got t=%0d acks=%0d want t=5 acks=1", sel[k], cap_done_t, cap_ack); end
            checks++; if (cap_n > 0 && cap_wr_low[0] != int'(WR_PULSE)) begin errors++; $display("FAIL ocw%0d_strobe: got %0d want %0d", sel[k], cap_wr_low[0], WR_PULSE); end
            checks++; if (cap_err != 0 || cap_tail_bus != 0 || cap_unstable || cap_idle_bad) begin errors++; $display("FAIL ocw%0d_clean: got err=%0d tail=%0d unst=%b idle=%b want 0", sel[k], cap_err, cap_tail_bus, cap_unstable, cap_idle_bad); end
        end
    endtask

    task automatic test_back_to_back();
        ifc.ocw_sel = 2'd1; ifc.ocw_data = to_bus(8'hC3); ifc.ocw_req = 1'b1;
        @(posedge clk); #1;
        capture(40, 1, 2, -1);
        checks++; if (cap_n != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", cap_n); end
        for (int i = 0; i < 2 && i < cap_n; i++) begin
            checks++; if (cap_a0[i] !== 1'b1 || cap_d[i] !== 8'hC3) begin errors++; $display("FAIL b2b_word%0d: got a0=%b d=%h want a0=1 d=c3", i, cap_a0[i], cap_d[i]); end
        end
        checks++; if (cap_done_t != 11 || cap_ack != 2) begin errors++; $display("FAIL b2b_ack: got t=%0d acks=%0d want t=11 acks=2", cap_done_t, cap_ack); end
    endtask

    task automatic test_sel_zero();
        int n_err = 0, cs_low = 0;
        ifc.ocw_sel = 2'd0; ifc.ocw_data = to_bus(8'h33); ifc.ocw_req = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (ifc.ocw_err === 1'b1) n_err++;
            if (ifc.cs_neg !== 1'b1) cs_low++;
        end
        ifc.ocw_req = 1'b0;
        checks++; if (n_err != 1 || cs_low != 0) begin errors++; $display("FAIL sel_zero: got errs=%0d bus=%0d want 1 0", n_err, cs_low); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_and_ocw();
        int en;
        en = 2 + EXTRA;
        ifc.single_mode = 1'b1; ifc.icw4_needed = 1'b0; ifc.level_trigger = 1'b0; ifc.aeoi = 1'b0;
        ifc.vector_base = 5'b00100; ifc.init_imr = to_bus(8'h81);
        ifc.ocw_sel = 2'd1; ifc.ocw_data = to_bus(8'h77); ifc.ocw_req = 1'b1;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        capture(60, 0, 0, -1);
        checks++; if (cap_n != en) begin errors++; $display("FAIL collide_count: got %0d want %0d", cap_n, en); end
        checks++; if (cap_n > 1 && (cap_a0[1] !== 1'b1 || cap_d[1] !== 8'h20)) begin errors++; $display("FAIL collide_icw2: got a0=%b d=%h want a0=1 d=20", cap_a0[1], cap_d[1]); end
        checks++; if (cap_err != 1 || cap_ack != 0) begin errors++; $display("FAIL collide_reject: got err=%0d ack=%0d want 1 0", cap_err, cap_ack); end
        checks++; if (cap_done_t != 5 * en || cap_tail_bus != 0) begin errors++; $display("FAIL collide_done: got t=%0d tail=%0d want %0d 0", cap_done_t, cap_tail_bus, 5 * en); end
    endtask

    task automatic test_reset_mid();
        int en;
        en = 2 + EXTRA;
        ifc.single_mode = 1'b1; ifc.icw4_needed = 1'b0; ifc.level_trigger = 1'b1;
        ifc.vector_base = 5'b10001; ifc.init_imr = to_bus(8'h0F);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (ifc.wr_neg !== 1'b0 || ifc.a0 !== 1'b1 || ifc.cs_neg !== 1'b0) begin errors++; $display("FAIL midrst_in_strobe: got wr=%b a0=%b cs=%b want 0 1 0", ifc.wr_neg, ifc.a0, ifc.cs_neg); end
        #1 rst = 1'b1;
        #1;
        checks++; if (ifc.wr_neg !== 1'b1 || ifc.cs_neg !== 1'b1) begin errors++; $display("FAIL midrst_bus: got wr=%b cs=%b want 1 1", ifc.wr_neg, ifc.cs_neg); end
        checks++; if (ifc.init_done !== 1'b0 || ifc.busy !== 1'b0 || ifc.a0 !== 1'b0 || ifc.data_bus_buffer !== 8'h00) begin errors++; $display("FAIL midrst_state: got done=%b busy=%b a0=%b d=%h want 0 0 0 00", ifc.init_done, ifc.busy, ifc.a0, ifc.data_bus_buffer); end
        @(posedge clk); #1 rst = 1'b0;
        begin
            int act = 0;
            repeat (4) begin @(posedge clk); #1; if (ifc.cs_neg !== 1'b1) act++; end
            checks++; if (act != 0) begin errors++; $display("FAIL midrst_quiet: bus active %0d cycles want 0", act); end
        end
        ifc.start = 1'b1;
        @(posedge clk); #1;
        capture(60, 0, 0, -1);
        checks++; if (cap_n != en) begin errors++; $display("FAIL replay_count: got %0d want %0d", cap_n, en); end
        checks++; if (cap_n > 0 && (cap_a0[0] !== 1'b0 || cap_d[0] !== 8'h1A)) begin errors++; $display("FAIL replay_icw1: got a0=%b d=%h want a0=0 d=1a", cap_a0[0], cap_d[0]); end
        checks++; if (cap_done_t != 5 * en) begin errors++; $display("FAIL replay_done: got %0d want %0d", cap_done_t, 5 * en); end
    endtask

    initial begin
        test_reset();
        test_ocw_before_init();
        test_icw_single();
        test_icw_full();
        test_ocw();
        test_back_to_back();
        test_sel_zero();
        test_start_and_ocw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
